keypad_multitap_encoder: RTL and testbench
==========================================

Name: keypad_multitap_encoder

Overview:
- Sits upstream of the game controller on both host and player boards.
- Scans the 4x4 matrix keypad, synchronises and debounces the row lines, and turns repeated taps on a key into one ASCII letter (multi-tap).
- Emits single-cycle strobes for a submitted letter and a submitted word.
- Exposes the pending, not-yet-submitted character so the LCD row builder can preview it.

Parameters:
- SCAN_CYCLES, 4: clock cycles each column is driven before advancing; minimum 3.
- DEBOUNCE_CYCLES, 20: consecutive identical samples required to accept a press or a release (20 ms at 1 kHz clk).

Ports:
- clk  in  1  system clock (1 kHz nominal).
- rst  in  1  synchronous active-high reset.
- row  in  4  keypad row sense; row[i] high = key in row i of the driven column is closed. Asynchronous.
- col  out  4  one-hot column drive; col[j] high drives column j.
- pending_char  out  8  ASCII of the current multi-tap selection; 0x20 when none is pending.
- letter  out  8  ASCII of the last submitted letter; held until the next submit.
- letter_valid  out  1  one-cycle strobe: letter updated.
- word_valid  out  1  one-cycle strobe: submit-word key accepted.

Behaviour:
- Reset values (synchronous; take effect on the first edge with rst=1, and abort any state): col=4'b0001, pending_char=8'h20, letter=8'h00, letter_valid=0, word_valid=0, state=SCAN, all counters=0, pending=0.
- row passes through a 2-flop synchroniser before use (row_s).
- Key index k = 4*r + c, where r is the set bit of row_s and c is the set bit of col.
  - Keys 0..8 are letter keys. Key k covers ASCII 'A'+3k, 'A'+3k+1, 'A'+3k+2, clipped at 'Z', so key 8 covers only Y and Z (group size 2). All other letter keys have group size 3.
  - Keys 9, 10, 11 and 15 are ignored.
  - Key 12 = submit letter, key 13 = clear, key 14 = submit word.
- SCAN state:
  - The dwell counter runs 0..SCAN_CYCLES-1. row_s is evaluated only on the last dwell cycle.
  - row_s==0: col rotates left (4'b1000 wraps to 4'b0001) and the dwell restarts.
  - row_s exactly one-hot: capture row_s, go to DB_PRESS, freeze col, clear the debounce counter.
  - row_s with more than one bit set: treated as no key; col advances.
- DB_PRESS:
  - Each cycle row_s equals the captured value, the counter increments.
  - Any mismatch (including zero) returns to SCAN with the same col and dwell=0.
  - When the DEBOUNCE_CYCLES-th matching sample is reached, go to HELD and issue one press event for key k.
- Press event actions (outputs registered on the same edge that enters HELD, so they are visible in the first HELD cycle):
  - Letter key, same key as pending: tap index = (tap+1) mod group size.
  - Letter key, different key or none pending: key latched, tap=0, pending=1.
  - pending_char = ASCII of the latched key and tap.
  - Key 12 with pending=1: letter=pending_char, letter_valid=1 for one cycle, pending=0, pending_char=8'h20. With pending=0: no action.
  - Key 13: pending=0, pending_char=8'h20.
  - Key 14: word_valid=1 for one cycle. The pending selection is untouched.
  - Ignored keys: no output change.
- HELD: col stays frozen. row_s==0 goes to DB_RELEASE with counter=0. Holding a key never repeats the press event.
- DB_RELEASE:
  - DEBOUNCE_CYCLES consecutive zero samples: go to SCAN and advance col.
  - Any nonzero sample: return to HELD with no new event.
- letter_valid and word_valid are never high simultaneously and are never high for two consecutive cycles.

Test Plan:
- Reset: hold rst 2 cycles, then release. Require col=0001, pending_char=0x20, letter=0x00, both strobes 0, and col rotating 0001→0010→0100→1000→0001 every 4 cycles with row=0.
- Multi-tap wrap: press r0 while col=0001 for 30 cycles, then release 30, four times. Require pending_char sequence 0x41, 0x42, 0x43, 0x41 ('A','B','C','A'), one update per press.
- Letter submit: tap r0c1 once (pending 0x44 'D'), then press r3c0. Require letter=0x44 with letter_valid high for exactly 1 cycle, and pending_char=0x20 after.
- Bounce and short group: toggle r2c0 for 10 cycles and release; require no change. Then tap r2c0 three times; require pending_char 0x59, 0x5A, 0x59.
- Control keys: with nothing pending, press r3c0; require no letter_valid. Press r3c2; require word_valid high for 1 cycle. Drive row=0011; require it to be ignored with col continuing to scan.
- Reset mid-operation: assert rst during DB_PRESS and again during HELD with 'E' pending. Require all reset values on the next cycle, and that the subsequent release produces no event.

Source files
------------

// File: rtl/keypad_multitap_encoder.sv
// 4x4 matrix keypad scanner with row synchronisation, press/release debounce and
// multi-tap letter entry producing submit-letter / submit-word strobes.
module keypad_multitap_encoder #(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] pending_char,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       word_valid
);

    localparam int unsigned DW = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [7:0]  CHAR_NONE = 8'h20;
    localparam logic [3:0]  KEY_LAST_LETTER = 4'd8;
    localparam logic [3:0]  KEY_SUBMIT = 4'd12;
    localparam logic [3:0]  KEY_CLEAR  = 4'd13;
    localparam logic [3:0]  KEY_WORD   = 4'd14;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DB_PRESS,
        ST_HELD,
        ST_DB_RELEASE
    } state_t;

    state_t        state_q;
    logic [3:0]    row_m_q;
    logic [3:0]    row_s_q;
    logic [3:0]    cap_q;
    logic [3:0]    col_q;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] cnt_q;
    logic          pending_q;
    logic [3:0]    pkey_q;
    logic [1:0]    tap_q;
    logic [7:0]    pchar_q;
    logic [7:0]    letter_q;
    logic          letter_valid_q;
    logic          word_valid_q;

    logic          row_onehot;
    logic [3:0]    key_idx;
    logic          is_letter;
    logic [1:0]    grp_last;
    logic [1:0]    tap_d;
    logic [7:0]    char_d;

    function automatic logic [1:0] enc4(input logic [3:0] v);
        case (v)
            4'b0010: enc4 = 2'd1;
            4'b0100: enc4 = 2'd2;
            4'b1000: enc4 = 2'd3;
            default: enc4 = 2'd0;
        endcase
    endfunction

    // Key decode and next multi-tap selection from the captured row and frozen column.
    always_comb begin
        row_onehot = (row_s_q != 4'd0) && ((row_s_q & (row_s_q - 4'd1)) == 4'd0);
        key_idx    = {enc4(cap_q), enc4(col_q)};
        is_letter  = (key_idx <= KEY_LAST_LETTER);
        grp_last   = (key_idx == KEY_LAST_LETTER) ? 2'd1 : 2'd2;
        tap_d      = 2'd0;
        if (pending_q && (pkey_q == key_idx)) begin
            tap_d = (tap_q >= grp_last) ? 2'd0 : tap_q + 2'd1;
        end
        char_d = 8'd65 + (8'(key_idx) * 8'd3) + 8'(tap_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SCAN;
            row_m_q        <= 4'd0;
            row_s_q        <= 4'd0;
            cap_q          <= 4'd0;
            col_q          <= 4'b0001;
            dwell_q        <= '0;
            cnt_q          <= '0;
            pending_q      <= 1'b0;
            pkey_q         <= 4'd0;
            tap_q          <= 2'd0;
            pchar_q        <= CHAR_NONE;
            letter_q       <= 8'h00;
            letter_valid_q <= 1'b0;
            word_valid_q   <= 1'b0;
        end else begin
            row_m_q        <= row;
            row_s_q        <= row_m_q;
            letter_valid_q <= 1'b0;
            word_valid_q   <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (dwell_q == DW'(SCAN_CYCLES - 1)) begin
                        dwell_q <= '0;
                        if (row_onehot) begin
                            state_q <= ST_DB_PRESS;
                            cap_q   <= row_s_q;
                            cnt_q   <= '0;
                        end else begin
                            col_q <= {col_q[2:0], col_q[3]};
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                ST_DB_PRESS: begin
                    if (row_s_q != cap_q) begin
                        state_q <= ST_SCAN;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        // Accepted press: act once, holding never repeats.
                        state_q <= ST_HELD;
                        if (is_letter) begin
                            pkey_q    <= key_idx;
                            tap_q     <= tap_d;
                            pending_q <= 1'b1;
                            pchar_q   <= char_d;
                        end else if (key_idx == KEY_SUBMIT) begin
                            if (pending_q) begin
                                letter_q       <= pchar_q;
                                letter_valid_q <= 1'b1;
                                pending_q      <= 1'b0;
                                pchar_q        <= CHAR_NONE;
                            end
                        end else if (key_idx == KEY_CLEAR) begin
                            pending_q <= 1'b0;
                            pchar_q   <= CHAR_NONE;
                        end else if (key_idx == KEY_WORD) begin
                            word_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (row_s_q == 4'd0) begin
                        state_q <= ST_DB_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                ST_DB_RELEASE: begin
                    if (row_s_q != 4'd0) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        state_q <= ST_SCAN;
                        dwell_q <= '0;
                        col_q   <= {col_q[2:0], col_q[3]};
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign col          = col_q;
    assign pending_char = pchar_q;
    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign word_valid   = word_valid_q;

endmodule

// File: tb/tb_keypad_multitap_encoder.sv
// Directed bench for keypad_multitap_encoder: a keypad model closes rows only while
// the matching column is driven; expected characters are hand-computed.
module tb_keypad_multitap_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] pending_char;
    logic [7:0] letter;
    logic       letter_valid;
    logic       word_valid;

    logic       key_dn  = 1'b0;
    logic [1:0] key_r   = 2'd0;
    logic [1:0] key_c   = 2'd0;
    logic       ovr_en  = 1'b0;
    logic [3:0] ovr_val = 4'd0;

    int n_chk  = 0;
    int n_pass = 0;
    int lv_cnt = 0;
    int wv_cnt = 0;
    int pc_chg = 0;
    int col_chg = 0;
    int viol   = 0;
    logic       lv_prev = 1'b0;
    logic       wv_prev = 1'b0;
    logic [7:0] pc_prev = 8'h20;
    logic [3:0] col_prev = 4'b0001;

    keypad_multitap_encoder #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .row          (row),
        .col          (col),
        .pending_char (pending_char),
        .letter       (letter),
        .letter_valid (letter_valid),
        .word_valid   (word_valid)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed key shorts its row only while its column is driven.
    always_comb begin
        if (ovr_en) row = ovr_val;
        else if (key_dn && (col == (4'b0001 << key_c))) row = 4'b0001 << key_r;
        else row = 4'b0000;
    end

    // Strobe and output-change bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (letter_valid) lv_cnt++;
            if (word_valid) wv_cnt++;
            if (letter_valid && word_valid) viol++;
            if ((letter_valid && lv_prev) || (word_valid && wv_prev)) viol++;
            if (pending_char != pc_prev) pc_chg++;
            if (col != col_prev) col_chg++;
        end
        lv_prev  = letter_valid;
        wv_prev  = word_valid;
        pc_prev  = pending_char;
        col_prev = col;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        lv_cnt = 0; wv_cnt = 0; pc_chg = 0; col_chg = 0;
    endtask

    // Wait until the scan has just moved onto column c (bounded).
    task automatic wait_col(input logic [1:0] c);
        logic [3:0] tgt;
        logic [3:0] prev;
        logic       found;
        tgt = 4'b0001 << c;
        prev = col;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick(1);
            if (col == tgt && prev != tgt) found = 1'b1;
            prev = col;
        end
        if (!found) check("wait_col", 32'(col), 32'(tgt));
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold);
        wait_col(c);
        key_r = r; key_c = c; key_dn = 1'b1;
        tick(hold);
    endtask

    task automatic release_key(input int n);
        key_dn = 1'b0;
        tick(n);
    endtask

    task automatic tap_expect(input string tag, input logic [1:0] r, input logic [1:0] c,
                              input logic [7:0] exp);
        clear_counts();
        press(r, c, 30);
        check(tag, 32'(pending_char), 32'(exp));
        release_key(30);
        check({tag, "_updates"}, 32'(pc_chg), 1);
    endtask

    task automatic tap(input logic [1:0] r, input logic [1:0] c);
        press(r, c, 30);
        release_key(30);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_col"}, 32'(col), 'h1);
        check({tag, "_pchar"}, 32'(pending_char), 'h20);
        check({tag, "_letter"}, 32'(letter), 'h0);
        check({tag, "_lv"}, 32'(letter_valid), 0);
        check({tag, "_wv"}, 32'(word_valid), 0);
    endtask

    initial begin
        // Reset and free-running scan
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_reset_vals("reset");
        tick(3);  check("scan_hold", 32'(col), 'h1);
        tick(1);  check("scan_c1", 32'(col), 'h2);
        tick(4);  check("scan_c2", 32'(col), 'h4);
        tick(4);  check("scan_c3", 32'(col), 'h8);
        tick(4);  check("scan_wrap", 32'(col), 'h1);

        // Multi-tap wrap on key 0
        tap_expect("tap_A1", 2'd0, 2'd0, 8'h41);
        tap_expect("tap_B",  2'd0, 2'd0, 8'h42);
        tap_expect("tap_C",  2'd0, 2'd0, 8'h43);
        tap_expect("tap_A2", 2'd0, 2'd0, 8'h41);
        check("multitap_no_lv", 32'(lv_cnt), 0);

        // Letter submit
        tap_expect("tap_D", 2'd0, 2'd1, 8'h44);
        clear_counts();
        tap(2'd3, 2'd0);
        check("submit_letter", 32'(letter), 'h44);
        check("submit_lv_pulses", 32'(lv_cnt), 1);
        check("submit_pchar", 32'(pending_char), 'h20);

        // Bounce rejection, then short group on key 8
        clear_counts();
        wait_col(2'd0);
        key_r = 2'd2; key_c = 2'd0;
        for (int i = 0; i < 10; i++) begin
            key_dn = ~key_dn;
            tick(1);
        end
        release_key(30);
        check("bounce_pchar", 32'(pending_char), 'h20);
        check("bounce_updates", 32'(pc_chg), 0);
        tap_expect("tap_Y1", 2'd2, 2'd0, 8'h59);
        tap_expect("tap_Z",  2'd2, 2'd0, 8'h5A);
        tap_expect("tap_Y2", 2'd2, 2'd0, 8'h59);

        // Control keys
        tap(2'd3, 2'd1);
        check("clear_pchar", 32'(pending_char), 'h20);
        clear_counts();
        tap(2'd3, 2'd0);
        check("submit_empty_lv", 32'(lv_cnt), 0);
        check("submit_empty_letter", 32'(letter), 'h44);
        tap_expect("tap_M", 2'd1, 2'd0, 8'h4D);
        clear_counts();
        tap(2'd3, 2'd2);
        check("word_pulses", 32'(wv_cnt), 1);
        check("word_keeps_pchar", 32'(pending_char), 'h4D);
        clear_counts();
        tap(2'd2, 2'd1);
        check("ignored_key_pchar", 32'(pending_char), 'h4D);

        // Two rows closed at once is not a key
        clear_counts();
        ovr_en = 1'b1; ovr_val = 4'b0011;
        tick(40);
        check("multirow_scan", 32'(col_chg), 10);
        check("multirow_updates", 32'(pc_chg), 0);
        check("multirow_strobes", 32'(lv_cnt + wv_cnt), 0);
        ovr_en = 1'b0;
        tick(5);

        // Reset while debouncing a press
        tap_expect("tap_D2", 2'd0, 2'd1, 8'h44);
        tap_expect("tap_E",  2'd0, 2'd1, 8'h45);
        press(2'd0, 2'd0, 10);
        rst = 1'b1;
        key_dn = 1'b0;
        tick(1);
        check_reset_vals("rst_dbpress");
        rst = 1'b0;
        clear_counts();
        tick(40);
        check("rst_dbpress_updates", 32'(pc_chg), 0);
        check("rst_dbpress_strobes", 32'(lv_cnt + wv_cnt), 0);

        // Reset while a key is held with 'E' pending
        tap_expect("tap_D3", 2'd0, 2'd1, 8'h44);
        tap_expect("tap_E2", 2'd0, 2'd1, 8'h45);
        press(2'd2, 2'd1, 26);
        check("held_col_frozen", 32'(col), 'h2);
        check("held_pchar", 32'(pending_char), 'h45);
        rst = 1'b1;
        tick(1);
        check_reset_vals("rst_held");
        rst = 1'b0;
        key_dn = 1'b0;
        clear_counts();
        tick(40);
        check("rst_held_updates", 32'(pc_chg), 0);
        check("rst_held_strobes", 32'(lv_cnt + wv_cnt), 0);
        check("rst_held_pchar", 32'(pending_char), 'h20);

        check("strobe_rules", 32'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
